// File: rtl/lcd_frame_writer_pkg.sv
// Shared definitions for the 2x16 HD44780 frame writer: FSM states, LCD command bytes, line bases.
package lcd_defs;

   typedef enum logic [2:0] {
      PWR_WAIT, INIT, SET_ADDR, WR_CHAR, XFER, XWAIT, IDLE
   } lcdState_t;

   typedef enum logic [2:0] {
      TX_IDLE, TX_SETUP, TX_EHIGH, TX_HOLD, TX_GAP
   } txState_t;

   localparam logic [7:0] CMD_FUNCSET = 8'h28;
   localparam logic [7:0] CMD_ENTRY   = 8'h06;
   localparam logic [7:0] CMD_DISPON  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_SETADDR = 8'h80;
   localparam logic [7:0] LINE1_BASE  = 8'h00;
   localparam logic [7:0] LINE2_BASE  = 8'h40;
   localparam logic [2:0] LAST_STEP   = 3'd7;

   // Steps 0-3 are bare upper nibbles (8-bit wake-up, then switch to 4-bit mode).
   function automatic logic [7:0] initByte(input logic [2:0] step);
      case (step)
         3'd0, 3'd1, 3'd2: initByte = 8'h30;
         3'd3:             initByte = 8'h20;
         3'd4:             initByte = CMD_FUNCSET;
         3'd5:             initByte = CMD_ENTRY;
         3'd6:             initByte = CMD_DISPON;
         default:          initByte = CMD_CLEAR;
      endcase
   endfunction

   function automatic logic initIsNibble(input logic [2:0] step);
      initIsNibble = (step < 3'd4);
   endfunction

   function automatic logic [7:0] addrByte(input logic [4:0] idx);
      addrByte = CMD_SETADDR | (idx[4] ? LINE2_BASE : LINE1_BASE) | {4'h0, idx[3:0]};
   endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one byte (or a lone upper nibble) on the LCD 4-bit bus with setup, E strobe and hold timing.
// Busy from start to the single-cycle done pulse; start is only honoured while idle.
module lcd_nibble_tx
   import lcd_defs::*;
#(
   parameter int T_EHIGH  = 12,
   parameter int T_NIBGAP = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] txData,
   input  logic       rs,
   input  logic       nibbleOnly,
   output logic       done,
   output logic [3:0] sfD,
   output logic       lcdE,
   output logic       lcdRs
);

   txState_t   state, stateNext;
   logic [7:0] cnt, cntNext;
   logic [3:0] lowNib, lowNibNext, sfDNext;
   logic       lowPhase, lowPhaseNext, single, singleNext;
   logic       eNext, rsNext, doneNext;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= TX_IDLE;
         cnt      <= '0;
         lowNib   <= '0;
         lowPhase <= 1'b0;
         single   <= 1'b0;
         sfD      <= '0;
         lcdE     <= 1'b0;
         lcdRs    <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         lowNib   <= lowNibNext;
         lowPhase <= lowPhaseNext;
         single   <= singleNext;
         sfD      <= sfDNext;
         lcdE     <= eNext;
         lcdRs    <= rsNext;
         done     <= doneNext;
      end
   end

   always_comb begin
      stateNext    = state;
      cntNext      = cnt;
      lowNibNext   = lowNib;
      lowPhaseNext = lowPhase;
      singleNext   = single;
      sfDNext      = sfD;
      eNext        = lcdE;
      rsNext       = lcdRs;
      doneNext     = 1'b0;
      case (state)
         TX_IDLE: begin
            if (start) begin
               sfDNext      = txData[7:4];
               lowNibNext   = txData[3:0];
               rsNext       = rs;
               singleNext   = nibbleOnly;
               lowPhaseNext = 1'b0;
               cntNext      = '0;
               stateNext    = TX_SETUP;
            end
         end
         TX_SETUP: begin
            if (cnt == 8'd1) begin
               eNext     = 1'b1;
               cntNext   = '0;
               stateNext = TX_EHIGH;
            end else begin
               cntNext = cnt + 8'd1;
            end
         end
         TX_EHIGH: begin
            if (cnt == 8'(T_EHIGH - 1)) begin
               eNext     = 1'b0;
               stateNext = TX_HOLD;
            end else begin
               cntNext = cnt + 8'd1;
            end
         end
         TX_HOLD: begin
            if (lowPhase || single) begin
               doneNext  = 1'b1;
               stateNext = TX_IDLE;
            end else begin
               cntNext   = '0;
               stateNext = TX_GAP;
            end
         end
         TX_GAP: begin
            if (cnt == 8'(T_NIBGAP - 1)) begin
               sfDNext      = lowNib;
               lowPhaseNext = 1'b1;
               cntNext      = '0;
               stateNext    = TX_SETUP;
            end else begin
               cntNext = cnt + 8'd1;
            end
         end
         default: stateNext = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/lcd_frame_writer.sv
// Shadow frame with dirty bits for a 2x16 HD44780; runs init, then streams dirty cells as address+char.
// Writes accepted every cycle with no backpressure; identical writes coalesce, none are dropped.
module lcd_frame_writer
   import lcd_defs::*;
#(
   parameter int T_POWERUP = 750000,
   parameter int T_INIT1   = 205000,
   parameter int T_INIT2   = 5000,
   parameter int T_CMD     = 2000,
   parameter int T_CLEAR   = 82000,
   parameter int T_EHIGH   = 12,
   parameter int T_NIBGAP  = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       writeEnable,
   input  logic [4:0] location,
   input  logic [7:0] data,
   output logic       ready,
   output logic       busy,
   output logic [3:0] SF_D,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW
);

   lcdState_t   state, stateNext, phase;
   logic [2:0]  step;
   logic [19:0] waitCnt, waitVal;
   logic [4:0]  ptr, capIdx, pick;
   logic [7:0]  capChar, txByte;
   logic [7:0]  shadow [32];
   logic [31:0] dirty, dirtyNext;
   logic        found, wrNew, capture, loadWait, stepInc, setReady;
   logic        txStart, txRs, txNib, txDone;

   assign LCD_RW = 1'b0;
   assign wrNew  = writeEnable && (shadow[location] != data);

   // Lowest dirty index at or after the scan pointer, wrapping past 31.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      for (int i = 0; i < 32; i++) begin
         if (!found && dirty[ptr + 5'(i)]) begin
            found = 1'b1;
            pick  = ptr + 5'(i);
         end
      end
   end

   // A same-cycle write re-dirties the cell being captured, so its new value goes out later.
   always_comb begin
      dirtyNext = dirty;
      if (capture) dirtyNext[pick] = 1'b0;
      if (wrNew)   dirtyNext[location] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= PWR_WAIT;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      txStart   = 1'b0;
      txByte    = 8'h00;
      txRs      = 1'b0;
      txNib     = 1'b0;
      capture   = 1'b0;
      loadWait  = 1'b0;
      waitVal   = '0;
      stepInc   = 1'b0;
      setReady  = 1'b0;
      case (state)
         PWR_WAIT: if (waitCnt == '0) stateNext = INIT;
         INIT: begin
            txStart   = 1'b1;
            txByte    = initByte(step);
            txNib     = initIsNibble(step);
            stateNext = XFER;
         end
         SET_ADDR: begin
            txStart   = 1'b1;
            txByte    = addrByte(capIdx);
            stateNext = XFER;
         end
         WR_CHAR: begin
            txStart   = 1'b1;
            txByte    = capChar;
            txRs      = 1'b1;
            stateNext = XFER;
         end
         XFER: begin
            if (txDone) begin
               loadWait  = 1'b1;
               stateNext = XWAIT;
               if (phase == INIT) begin
                  case (step)
                     3'd0:      waitVal = 20'(T_INIT1 - 1);
                     3'd1:      waitVal = 20'(T_INIT2 - 1);
                     LAST_STEP: waitVal = 20'(T_CLEAR - 1);
                     default:   waitVal = 20'(T_CMD - 1);
                  endcase
               end else begin
                  waitVal = 20'(T_CMD - 1);
               end
            end
         end
         XWAIT: begin
            if (waitCnt == '0) begin
               case (phase)
                  INIT: begin
                     if (step == LAST_STEP) begin
                        setReady  = 1'b1;
                        stateNext = IDLE;
                     end else begin
                        stepInc   = 1'b1;
                        stateNext = INIT;
                     end
                  end
                  SET_ADDR: stateNext = WR_CHAR;
                  default:  stateNext = IDLE;
               endcase
            end
         end
         IDLE: begin
            if (found) begin
               capture   = 1'b1;
               stateNext = SET_ADDR;
            end
         end
         default: stateNext = PWR_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         waitCnt <= 20'(T_POWERUP - 1);
         step    <= '0;
         ptr     <= '0;
         capIdx  <= '0;
         capChar <= 8'h20;
         phase   <= INIT;
         ready   <= 1'b0;
         busy    <= 1'b0;
         dirty   <= '0;
         for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
      end else begin
         dirty <= dirtyNext;
         busy  <= (stateNext != IDLE) | (|dirtyNext);
         if (loadWait)             waitCnt <= waitVal;
         else if (waitCnt != '0)   waitCnt <= waitCnt - 20'd1;
         if (stepInc)  step  <= step + 3'd1;
         if (txStart)  phase <= state;
         if (setReady) ready <= 1'b1;
         if (capture) begin
            capIdx  <= pick;
            capChar <= shadow[pick];
            ptr     <= pick + 5'd1;
         end
         if (wrNew) shadow[location] <= data;
      end
   end

   lcd_nibble_tx #(
      .T_EHIGH (T_EHIGH),
      .T_NIBGAP(T_NIBGAP)
   ) nibbleTx (
      .clk       (clk),
      .rst       (rst),
      .start     (txStart),
      .txData    (txByte),
      .rs        (txRs),
      .nibbleOnly(txNib),
      .done      (txDone),
      .sfD       (SF_D),
      .lcdE      (LCD_E),
      .lcdRs     (LCD_RS)
   );

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: bus decoder feeding a model HD44780 panel, directed cases plus random writes.
module tb_lcd_frame_writer;

   localparam int TEH = 3;

   logic       clk = 1'b0, rst = 1'b1, writeEnable = 1'b0;
   logic [4:0] location = '0;
   logic [7:0] data = '0;
   logic       ready, busy, LCD_E, LCD_RS, LCD_RW;
   logic [3:0] SF_D;

   lcd_frame_writer #(
      .T_POWERUP(20), .T_INIT1(15), .T_INIT2(8), .T_CMD(4),
      .T_CLEAR(10), .T_EHIGH(TEH), .T_NIBGAP(5)
   ) dut (
      .clk(clk), .rst(rst), .writeEnable(writeEnable), .location(location), .data(data),
      .ready(ready), .busy(busy), .SF_D(SF_D), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
   );

   always #5 clk = ~clk;

   int nCompared = 0, nMismatched = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {logic rs; logic [7:0] val;} busItem_t;
   busItem_t   obsQ[$];
   logic [7:0] ddram [128];
   logic [6:0] cursor = '0;
   logic [7:0] expShadow [32];
   int         dataWrites = 0, effective = 0;

   // Panel model: set-address moves the cursor, clear blanks, data writes auto-increment.
   task automatic applyByte(input logic rs, input logic [7:0] v);
      obsQ.push_back({rs, v});
      if (rs) begin
         ddram[cursor] = v;
         cursor = cursor + 7'd1;
         dataWrites++;
      end else if (v[7]) begin
         cursor = v[6:0];
      end else if (v == 8'h01) begin
         for (int i = 0; i < 128; i++) ddram[i] = 8'h20;
         cursor = '0;
      end
   endtask

   int         nibCnt = 0, eWidth = 0;
   logic       prevE = 1'b0, haveUpper = 1'b0, upperRs = 1'b0;
   logic [3:0] upperNib = '0;

   always @(negedge clk) begin
      if (rst) begin
         nibCnt = 0; eWidth = 0; prevE = 1'b0; haveUpper = 1'b0;
      end else begin
         if (LCD_E && !prevE) begin
            if (nibCnt < 4) begin
               obsQ.push_back({LCD_RS, 4'h0, SF_D});
            end else if (!haveUpper) begin
               haveUpper = 1'b1; upperNib = SF_D; upperRs = LCD_RS;
            end else begin
               haveUpper = 1'b0;
               checkVal("rs_consistent", 32'(LCD_RS), 32'(upperRs));
               applyByte(LCD_RS, {upperNib, SF_D});
            end
            nibCnt++;
         end
         if (LCD_E) begin
            eWidth++;
         end else if (prevE) begin
            checkVal("e_width", eWidth, TEH);
            checkVal("rw_low", 32'(LCD_RW), 0);
            eWidth = 0;
         end
         prevE = LCD_E;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wrCell(input logic [4:0] loc, input logic [7:0] d);
      writeEnable = 1'b1; location = loc; data = d;
      tick();
      writeEnable = 1'b0;
      if (expShadow[loc] != d) effective++;
      expShadow[loc] = d;
   endtask

   task automatic waitReady(input string tag);
      int n = 0;
      while (!ready && n < 5000) begin tick(); n++; end
      checkVal(tag, 32'(ready), 1);
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy && n < 20000) begin tick(); n++; end
      checkVal(tag, 32'(busy), 0);
   endtask

   task automatic expectItem(input string tag, input logic rs, input logic [7:0] v);
      busItem_t it;
      if (obsQ.size() == 0) begin
         checkVal({tag, "_present"}, obsQ.size(), 1);
      end else begin
         it = obsQ.pop_front();
         checkVal(tag, 32'(it), 32'({rs, v}));
      end
   endtask

   task automatic expectInit(input string tag);
      logic [7:0] initSeq [8] = '{8'h03, 8'h03, 8'h03, 8'h02, 8'h28, 8'h06, 8'h0C, 8'h01};
      for (int i = 0; i < 8; i++) expectItem($sformatf("%s_%0d", tag, i), 1'b0, initSeq[i]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 32; i++) expShadow[i] = 8'h20;
      for (int i = 0; i < 128; i++) ddram[i] = 8'h00;
      repeat (3) tick();
      checkVal("rst_sfd",   32'(SF_D), 0);
      checkVal("rst_e",     32'(LCD_E), 0);
      checkVal("rst_rs",    32'(LCD_RS), 0);
      checkVal("rst_rw",    32'(LCD_RW), 0);
      checkVal("rst_ready", 32'(ready), 0);
      checkVal("rst_busy",  32'(busy), 0);

      rst = 1'b0;
      wrCell(5'd9, 8'h20);
      waitReady("init_ready");
      expectInit("init");
      repeat (50) tick();
      checkVal("equal_write_no_xfer", obsQ.size(), 0);
      checkVal("idle_busy", 32'(busy), 0);

      // Rewrite cell 5 and write cell 2 while cell 5's first transfer is on the bus.
      wrCell(5'd5, 8'h41);
      n = 0;
      while (obsQ.size() < 1 && n < 2000) begin tick(); n++; end
      checkVal("addr_seen", obsQ.size(), 1);
      wrCell(5'd5, 8'h42);
      wrCell(5'd2, 8'h43);
      waitIdle("rewrite_idle");
      expectItem("ord_a0", 1'b0, 8'h85);
      expectItem("ord_d0", 1'b1, 8'h41);
      expectItem("ord_a1", 1'b0, 8'h82);
      expectItem("ord_d1", 1'b1, 8'h43);
      expectItem("ord_a2", 1'b0, 8'h85);
      expectItem("ord_d2", 1'b1, 8'h42);
      checkVal("ord_extra", obsQ.size(), 0);

      writeEnable = 1'b1; location = 5'd17; data = 8'h30;
      repeat (100) tick();
      writeEnable = 1'b0;
      expShadow[17] = 8'h30;
      waitIdle("hold_idle");
      expectItem("hold_addr", 1'b0, 8'hC1);
      expectItem("hold_data", 1'b1, 8'h30);
      checkVal("hold_once", obsQ.size(), 0);

      effective = 0;
      dataWrites = 0;
      for (int i = 0; i < 80; i++) begin
         wrCell(5'($urandom_range(0, 31)), 8'h41 + 8'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 30)) tick();
      end
      waitIdle("rand_idle");
      obsQ.delete();
      for (int c = 0; c < 32; c++)
         checkVal($sformatf("panel_%0d", c), 32'(ddram[c < 16 ? c : 64 + c - 16]), 32'(expShadow[c]));
      checkVal("rand_coalesce", 32'(dataWrites <= effective), 1);
      checkVal("rand_ready", 32'(ready), 1);

      // Reset while E is high.
      wrCell(5'd10, 8'h55);
      n = 0;
      while (!LCD_E && n < 2000) begin tick(); n++; end
      checkVal("e_seen", 32'(LCD_E), 1);
      rst = 1'b1;
      tick();
      checkVal("midrst_e",     32'(LCD_E), 0);
      checkVal("midrst_busy",  32'(busy), 0);
      checkVal("midrst_ready", 32'(ready), 0);
      for (int i = 0; i < 32; i++) expShadow[i] = 8'h20;
      tick();
      obsQ.delete();
      rst = 1'b0;
      waitReady("reinit_ready");
      expectInit("reinit");
      repeat (60) tick();
      checkVal("reinit_no_xfer", obsQ.size(), 0);
      checkVal("reinit_busy", 32'(busy), 0);
      checkVal("reinit_cell10", 32'(ddram[10]), 32'(expShadow[10]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
